// File: rtl/mips_mc_controller_if.sv
// Control/handshake bundle between the multicycle MIPS controller and its datapath/memory.
interface mips_mc_controller_if #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 memread;
  logic                 memwrite;
  logic                 membyteread;
  logic                 iord;
  logic                 irwrite;
  logic                 pcen;
  logic [1:0]           pcsrc;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 fault;
  logic [1:0]           fault_code;
  logic [CNT_W-1:0]     retired;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, membyteread, iord, irwrite, pcen, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite,
           fault, fault_code, retired
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, membyteread, iord, irwrite, pcen, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite,
           fault, fault_code, retired
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with memory ready/timeout handling and sticky fault.
// Define MIPS_MC_PERF_CNT_EN to enable the retired-instruction counter.
module mips_mc_controller #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  mips_mc_controller_if.master bus
);
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_q;
  logic [1:0]        fault_code_q, fault_code_nx;
  logic [2:0]        alu_c;
  logic              timeout_c;
  logic              wait_state_c;

  // Timeout fires on the cycle whose miss would bring the wait count to MAX_WAIT.
  assign wait_state_c = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout_c    = (MAX_WAIT != 0) && !bus.mem_ready &&
                        ((32'(wait_q) + 32'd1) == MAX_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_q       <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state        <= next_state;
      fault_code_q <= fault_code_nx;
      if (next_state != state)
        wait_q <= '0;
      else if (wait_state_c && !bus.mem_ready)
        wait_q <= wait_q + WAIT_W'(1);
    end
  end

  // Next-state and Moore strobes; &ready strobes also look at mem_ready.
  always_comb begin
    next_state      = state;
    fault_code_nx   = fault_code_q;
    alu_c           = 3'b000;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.membyteread = 1'b0;
    bus.iord        = 1'b0;
    bus.irwrite     = 1'b0;
    bus.pcen        = 1'b0;
    bus.pcsrc       = 2'b00;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.regdst      = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regwrite    = 1'b0;
    bus.fault       = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        alu_c       = ALU_ADD;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcen    = 1'b1;
          next_state  = S_DECODE;
        end else if (timeout_c) begin
          next_state    = S_FAULT;
          fault_code_nx = 2'b11;
        end
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        alu_c       = ALU_ADD;
        case (bus.op)
          OP_LW, OP_LB, OP_SW: next_state = S_MEMADR;
          OP_R:                next_state = S_RTYPE;
          OP_BEQ:              next_state = S_BRANCH;
          OP_ADDI:             next_state = S_ADDIEX;
          OP_J:                next_state = S_JUMP;
          default: begin
            next_state    = S_FAULT;
            fault_code_nx = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        alu_c       = ALU_ADD;
        next_state  = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.memread     = 1'b1;
        bus.iord        = 1'b1;
        bus.membyteread = (bus.op == OP_LB);
        if (bus.mem_ready) next_state = S_MEMWB;
        else if (timeout_c) begin
          next_state    = S_FAULT;
          fault_code_nx = 2'b11;
        end
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
        else if (timeout_c) begin
          next_state    = S_FAULT;
          fault_code_nx = 2'b11;
        end
      end
      S_RTYPE: begin
        bus.alusrca = 1'b1;
        next_state  = S_ALUWB;
        case (bus.funct)
          6'b100000: alu_c = ALU_ADD;
          6'b100010: alu_c = ALU_SUB;
          6'b100100: alu_c = ALU_AND;
          6'b100101: alu_c = ALU_OR;
          6'b101010: alu_c = ALU_SLT;
          default: begin
            next_state    = S_FAULT;
            fault_code_nx = 2'b10;
          end
        endcase
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        alu_c       = ALU_SUB;
        bus.pcsrc   = 2'b01;
        bus.pcen    = bus.zero;
        next_state  = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        alu_c       = ALU_ADD;
        next_state  = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc  = 2'b10;
        bus.pcen   = 1'b1;
        next_state = S_FETCH;
      end
      S_FAULT: bus.fault = 1'b1;
      default: next_state = S_IDLE;
    endcase
    bus.alucontrol = ALUCTRL_W'(alu_c);
  end

  assign bus.fault_code = fault_code_q;

`ifdef MIPS_MC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic             retire_c;

  // An instruction retires when its last state hands control back to FETCH.
  assign retire_c = (next_state == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                     (state == S_BRANCH) || (state == S_ADDIWB) || (state == S_JUMP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        retired_q <= '0;
    else if (retire_c) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed self-checking bench for mips_mc_controller (default MAX_WAIT=15).
module tb_mips_mc_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_mc_controller_if #(.ALUCTRL_W(3), .CNT_W(32)) bus ();

  mips_mc_controller #(.ALUCTRL_W(3), .MAX_WAIT(15), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [19:0] E_IDLE, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD_B, E_MEMWB,
               E_MEMWR, E_RTYPE_SUB, E_ALUWB, E_BR_T, E_BR_NT, E_ADDIEX, E_ADDIWB,
               E_JUMP, E_F01, E_F10, E_F11;

  function automatic logic [19:0] mk(input logic mr, mw, mb, io, ir, pe,
                                     input logic [1:0] ps, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic rd, mtr, rw, f, input logic [1:0] fc);
    return {mr, mw, mb, io, ir, pe, ps, sa, sb, alu, rd, mtr, rw, f, fc};
  endfunction

  function automatic logic [19:0] outs();
    return {bus.memread, bus.memwrite, bus.membyteread, bus.iord, bus.irwrite, bus.pcen,
            bus.pcsrc, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.fault, bus.fault_code};
  endfunction

  function automatic logic [31:0] er(input int n);
`ifdef MIPS_MC_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(0) & 32'(n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("rst_idle", 32'(outs()), 32'(E_IDLE));
    chk("rst_retired", bus.retired, 32'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    //            mr mw mb io ir pe ps    sa sb     alu     rd mt rw f  fc
    E_IDLE      = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b00);
    E_FETCH_W   = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 2'b00);
    E_FETCH_R   = mk(1, 0, 0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 2'b00);
    E_DECODE    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, 2'b00);
    E_MEMADR    = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 2'b00);
    E_MEMRD_B   = mk(1, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b00);
    E_MEMWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0, 2'b00);
    E_MEMWR     = mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b00);
    E_RTYPE_SUB = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b110, 0, 0, 0, 0, 2'b00);
    E_ALUWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0, 2'b00);
    E_BR_T      = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 2'b00);
    E_BR_NT     = mk(0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 2'b00);
    E_ADDIEX    = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 2'b00);
    E_ADDIWB    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0, 2'b00);
    E_JUMP      = mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0, 2'b00);
    E_F01       = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 1, 2'b01);
    E_F10       = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 1, 2'b10);
    E_F11       = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 1, 2'b11);

    rst_n = 1'b0;
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    nxt();
    nxt();
    #1 chk("reset_idle", 32'(outs()), 32'(E_IDLE));
    chk("reset_retired", bus.retired, 32'd0);
    rst_n = 1'b1;
    #1 chk("idle_after_release", 32'(outs()), 32'(E_IDLE));

    // Fetch stalled two cycles, completes on the third
    for (int i = 0; i < 2; i++) begin
      nxt(); bus.mem_ready = 1'b0;
      #1 chk("fetch_wait", 32'(outs()), 32'(E_FETCH_W));
    end
    nxt(); bus.mem_ready = 1'b1;
    #1 chk("fetch_ready", 32'(outs()), 32'(E_FETCH_R));

    // lb
    nxt(); bus.op = 6'b100000;
    #1 chk("lb_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("lb_memadr", 32'(outs()), 32'(E_MEMADR));
    nxt(); #1 chk("lb_memrd", 32'(outs()), 32'(E_MEMRD_B));
    nxt(); #1 chk("lb_memwb", 32'(outs()), 32'(E_MEMWB));
    chk("lb_retired_before", bus.retired, er(0));
    nxt(); #1 chk("lb_fetch", 32'(outs()), 32'(E_FETCH_R));
    chk("lb_retired", bus.retired, er(1));

    // beq taken, then not taken
    nxt(); bus.op = 6'b000100;
    #1 chk("beq_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); bus.zero = 1'b1;
    #1 chk("beq_taken", 32'(outs()), 32'(E_BR_T));
    nxt(); #1 chk("beq_fetch1", 32'(outs()), 32'(E_FETCH_R));
    chk("beq_retired1", bus.retired, er(2));
    nxt(); #1 chk("beq_decode2", 32'(outs()), 32'(E_DECODE));
    nxt(); bus.zero = 1'b0;
    #1 chk("beq_not_taken", 32'(outs()), 32'(E_BR_NT));
    nxt(); #1 chk("beq_fetch2", 32'(outs()), 32'(E_FETCH_R));
    chk("beq_retired2", bus.retired, er(3));

    // sw completing on the 15th wait cycle
    nxt(); bus.op = 6'b101011;
    #1 chk("sw_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("sw_memadr", 32'(outs()), 32'(E_MEMADR));
    for (int i = 0; i < 14; i++) begin
      nxt(); bus.mem_ready = 1'b0;
      #1 chk("sw_memwr_wait", 32'(outs()), 32'(E_MEMWR));
    end
    nxt(); bus.mem_ready = 1'b1;
    #1 chk("sw_memwr_last", 32'(outs()), 32'(E_MEMWR));
    nxt(); #1 chk("sw_fetch_nofault", 32'(outs()), 32'(E_FETCH_R));
    chk("sw_retired", bus.retired, er(4));

    // R-type sub
    nxt(); bus.op = 6'b000000; bus.funct = 6'b100010;
    #1 chk("sub_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("sub_rtype", 32'(outs()), 32'(E_RTYPE_SUB));
    nxt(); #1 chk("sub_aluwb", 32'(outs()), 32'(E_ALUWB));
    nxt(); #1 chk("sub_fetch", 32'(outs()), 32'(E_FETCH_R));
    chk("sub_retired", bus.retired, er(5));

    // addi and j
    nxt(); bus.op = 6'b001000;
    #1 chk("addi_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("addi_ex", 32'(outs()), 32'(E_ADDIEX));
    nxt(); #1 chk("addi_wb", 32'(outs()), 32'(E_ADDIWB));
    nxt(); #1 chk("addi_fetch", 32'(outs()), 32'(E_FETCH_R));
    nxt(); bus.op = 6'b000010;
    #1 chk("j_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("j_jump", 32'(outs()), 32'(E_JUMP));
    nxt(); #1 chk("j_fetch", 32'(outs()), 32'(E_FETCH_R));
    chk("j_retired", bus.retired, er(7));

    // sw timing out after 15 wait cycles; fault is absorbing
    nxt(); bus.op = 6'b101011;
    #1 chk("to_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("to_memadr", 32'(outs()), 32'(E_MEMADR));
    for (int i = 0; i < 15; i++) begin
      nxt(); bus.mem_ready = 1'b0;
      #1 chk("to_memwr_wait", 32'(outs()), 32'(E_MEMWR));
    end
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.mem_ready = (i == 1);
      #1 chk("to_fault11", 32'(outs()), 32'(E_F11));
      chk("to_retired_frozen", bus.retired, er(7));
    end

    // Illegal funct
    do_reset();
    nxt(); #1 chk("if_fetch", 32'(outs()), 32'(E_FETCH_R));
    nxt(); bus.op = 6'b000000; bus.funct = 6'b000011;
    #1 chk("if_decode", 32'(outs()), 32'(E_DECODE));
    nxt();
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.mem_ready = (i != 1);
      #1 chk("if_fault10", 32'(outs()), 32'(E_F10));
    end

    // Illegal op
    do_reset();
    nxt(); #1 chk("io_fetch", 32'(outs()), 32'(E_FETCH_R));
    nxt(); bus.op = 6'b111111;
    #1 chk("io_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("io_fault01", 32'(outs()), 32'(E_F01));
    nxt(); #1 chk("io_fault01_hold", 32'(outs()), 32'(E_F01));

    // Reset asserted mid-MEMWR drops memwrite immediately
    do_reset();
    nxt(); #1 chk("rw_fetch", 32'(outs()), 32'(E_FETCH_R));
    nxt(); bus.op = 6'b101011;
    #1 chk("rw_decode", 32'(outs()), 32'(E_DECODE));
    nxt(); #1 chk("rw_memadr", 32'(outs()), 32'(E_MEMADR));
    nxt(); bus.mem_ready = 1'b0;
    #1 chk("rw_memwr", 32'(outs()), 32'(E_MEMWR));
    #1 rst_n = 1'b0;
    #1 chk("rw_async_idle", 32'(outs()), 32'(E_IDLE));
    chk("rw_retired", bus.retired, 32'd0);
    nxt(); rst_n = 1'b1;
    #1 chk("rw_idle_release", 32'(outs()), 32'(E_IDLE));
    nxt(); bus.mem_ready = 1'b1;
    #1 chk("rw_fetch_after", 32'(outs()), 32'(E_FETCH_R));
    chk("rw_retired_after", bus.retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
